// File: rtl/fsim_cmd_serdes.sv
// fsim_cmd_serdes
//   Host-side front end for the FSim manager bridge. One wide read/write
//   command is taken in, sent out as a header word plus 32-bit payload words
//   on fsim_req, and the 32-bit response words from fsim_resp are gathered
//   into one wide response. Only one command is in flight at a time.
//
//   Handshakes: every channel uses valid/ready. A word or command moves on a
//   rising clock edge where both valid and ready are high. A producer keeps
//   valid and its payload stable until that edge. Ready may stay low for any
//   number of cycles.
//
//   Optional build macro: FSIM_TIMEOUT_EN. When it is defined, a wait for a
//   response gives up after TIMEOUT_CYCLES idle cycles and reports an error.
//   Response words that arrive late are drained while IDLE.
//
// Ports
//   clock, reset                  clock and synchronous active-high reset
//   cmd_valid/ready/opcode/addr/data
//                                 upstream command. Opcode 8'h01 is WRITE,
//                                 8'h02 is READ, any other value is illegal
//   fsim_req_valid/ready/bits     serialized request words (registered)
//   fsim_resp_valid/ready/bits    response words from the manager
//   rsp_valid/ready/data/err      upstream response
//   dbg_state_o                   current FSM state, for observation
module fsim_cmd_serdes #(
  parameter int ADDR_BITS      = 64,
  parameter int DATA_BITS      = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [7:0]           cmd_opcode,
  input  logic [ADDR_BITS-1:0] cmd_addr,
  input  logic [DATA_BITS-1:0] cmd_data,
  output logic                 fsim_req_valid,
  input  logic                 fsim_req_ready,
  output logic [31:0]          fsim_req_bits,
  input  logic                 fsim_resp_valid,
  output logic                 fsim_resp_ready,
  input  logic [31:0]          fsim_resp_bits,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_BITS-1:0] rsp_data,
  output logic                 rsp_err,
  output logic [2:0]           dbg_state_o
);

  localparam int AW = ADDR_BITS / 32;
  localparam int DW = DATA_BITS / 32;
  localparam int PW = AW + DW;
  localparam int CW = $clog2(PW + 2);

  localparam logic [7:0]  OP_WRITE = 8'h01;
  localparam logic [7:0]  OP_READ  = 8'h02;
  localparam logic [15:0] N_WR     = 16'(PW);
  localparam logic [15:0] N_RD     = 16'(AW);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_ADDR = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_WAIT = 3'd4;
  localparam logic [2:0] S_RSP  = 3'd5;

  if (ADDR_BITS < 32 || ADDR_BITS % 32 != 0 || DATA_BITS < 32 ||
      DATA_BITS % 32 != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("fsim_cmd_serdes: illegal parameter set");
  end

  logic [2:0]           state_q, state_d;
  logic [7:0]           opcode_q, opcode_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 req_valid_q, req_valid_d;
  logic [31:0]          req_bits_q, req_bits_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATA_BITS-1:0] rsp_data_q, rsp_data_d;
  logic                 rsp_err_q, rsp_err_d;

  logic [31:0]   pay_w [PW];
  logic [31:0]   nxt_word;
  logic [CW-1:0] nxt_idx;
  logic [CW-1:0] last_idx;
  logic          is_write;
  logic          req_fire;
  logic          resp_fire;
  logic          resp_rdy;

`ifdef FSIM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  // Stray words after a timeout are drained in IDLE.
  assign resp_rdy = (state_q == S_WAIT) || (state_q == S_IDLE);
`else
  assign resp_rdy = (state_q == S_WAIT);
`endif

  // The payload is viewed as one array of words: the address words first,
  // then the data words, each least-significant word first.
  always_comb begin
    for (int i = 0; i < AW; i++) pay_w[i] = addr_q[i*32 +: 32];
    for (int j = 0; j < DW; j++) pay_w[AW+j] = data_q[j*32 +: 32];
  end

  assign is_write  = (opcode_q == OP_WRITE);
  assign nxt_idx   = cnt_q + CW'(1);
  assign last_idx  = is_write ? CW'(PW - 1) : CW'(AW - 1);
  assign req_fire  = req_valid_q && fsim_req_ready;
  assign resp_fire = fsim_resp_valid && resp_rdy;

  always_comb begin
    nxt_word = '0;
    for (int i = 0; i < PW; i++) begin
      if (nxt_idx == CW'(i)) nxt_word = pay_w[i];
    end
  end

  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    addr_d      = addr_q;
    data_d      = data_q;
    req_valid_d = req_valid_q;
    req_bits_d  = req_bits_q;
    cnt_d       = cnt_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
`ifdef FSIM_TIMEOUT_EN
    tmo_d       = tmo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          opcode_d   = cmd_opcode;
          addr_d     = cmd_addr;
          data_d     = cmd_data;
          cnt_d      = '0;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          if (cmd_opcode == OP_WRITE || cmd_opcode == OP_READ) begin
            // The header goes out in the same edge as acceptance, so it is
            // valid one cycle after the command handshake.
            state_d     = S_HDR;
            req_valid_d = 1'b1;
            req_bits_d  = {cmd_opcode, 8'h00,
                           (cmd_opcode == OP_WRITE) ? N_WR : N_RD};
          end else begin
            state_d   = S_RSP;
            rsp_err_d = 1'b1;
          end
        end
      end
      S_HDR: begin
        if (req_fire) begin
          req_bits_d = pay_w[0];
          cnt_d      = '0;
          state_d    = S_ADDR;
        end
      end
      S_ADDR, S_DATA: begin
        // cnt_q is the index of the payload word now on the bus.
        if (req_fire) begin
          if (cnt_q == last_idx) begin
            req_valid_d = 1'b0;
            req_bits_d  = '0;
            cnt_d       = '0;
            state_d     = S_WAIT;
`ifdef FSIM_TIMEOUT_EN
            tmo_d       = '0;
`endif
          end else begin
            cnt_d      = nxt_idx;
            req_bits_d = nxt_word;
            state_d    = (nxt_idx < CW'(AW)) ? S_ADDR : S_DATA;
          end
        end
      end
      S_WAIT: begin
        if (resp_fire) begin
`ifdef FSIM_TIMEOUT_EN
          tmo_d = '0;
`endif
          if (is_write) begin
            rsp_err_d  = (fsim_resp_bits != 32'h0);
            rsp_data_d = '0;
            state_d    = S_RSP;
          end else begin
            for (int i = 0; i < DW; i++) begin
              if (cnt_q == CW'(i)) rsp_data_d[i*32 +: 32] = fsim_resp_bits;
            end
            cnt_d = nxt_idx;
            if (cnt_q == CW'(DW - 1)) state_d = S_RSP;
          end
        end
`ifdef FSIM_TIMEOUT_EN
        else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
          state_d    = S_RSP;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
`endif
      end
      S_RSP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      opcode_q    <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      req_valid_q <= 1'b0;
      req_bits_q  <= '0;
      cnt_q       <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
`ifdef FSIM_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      opcode_q    <= opcode_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      req_valid_q <= req_valid_d;
      req_bits_q  <= req_bits_d;
      cnt_q       <= cnt_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
`ifdef FSIM_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  // Outputs are forced low for as long as reset is held, not only after
  // the first reset edge.
  assign cmd_ready       = !reset && (state_q == S_IDLE);
  assign fsim_req_valid  = !reset && req_valid_q;
  assign fsim_req_bits   = reset ? '0 : req_bits_q;
  assign fsim_resp_ready = !reset && resp_rdy;
  assign rsp_valid       = !reset && (state_q == S_RSP);
  assign rsp_data        = reset ? '0 : rsp_data_q;
  assign rsp_err         = !reset && rsp_err_q;
  assign dbg_state_o     = reset ? 3'd0 : state_q;

endmodule

// File: tb/tb_fsim_cmd_serdes.sv
module tb_fsim_cmd_serdes;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_opcode;
  logic [63:0] cmd_addr;
  logic [63:0] cmd_data;
  logic        fsim_req_valid;
  logic        fsim_req_ready;
  logic [31:0] fsim_req_bits;
  logic        fsim_resp_valid;
  logic        fsim_resp_ready;
  logic [31:0] fsim_resp_bits;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_data;
  logic        rsp_err;
  logic [2:0]  dbg_state;

  int n_vec  = 0;
  int n_fail = 0;

  logic [31:0] exp_q[$];

  typedef struct packed {
    logic [7:0]       op;
    logic [63:0]      addr;
    logic [63:0]      data;
    int               nwords;
    logic [4:0][31:0] words;
    int               nresp;
    logic [1:0][31:0] resp;
    logic [63:0]      exp_data;
    logic             exp_err;
    logic             toggle;
    int               hold;
  } vec_t;

  vec_t vecs[6];

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run time limit reached");
    $fatal(1, "watchdog");
  end

  fsim_cmd_serdes #(
    .ADDR_BITS(64), .DATA_BITS(64), .TIMEOUT_CYCLES(16)
  ) dut (
    .clock(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .fsim_req_valid(fsim_req_valid), .fsim_req_ready(fsim_req_ready),
    .fsim_req_bits(fsim_req_bits),
    .fsim_resp_valid(fsim_resp_valid), .fsim_resp_ready(fsim_resp_ready),
    .fsim_resp_bits(fsim_resp_bits),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .dbg_state_o(dbg_state)
  );

  // scoreboard compare
  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 0);
    chk({tag, "_req_valid"}, fsim_req_valid, 0);
    chk({tag, "_req_bits"}, fsim_req_bits, 0);
    chk({tag, "_resp_ready"}, fsim_resp_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
  endtask

  function automatic vec_t mk(input logic [7:0] op, input logic [63:0] addr,
                              input logic [63:0] data, input logic [1:0][31:0] resp,
                              input int nresp, input logic [63:0] exp_data,
                              input logic exp_err, input logic toggle, input int hold);
    vec_t v;
    v = '0;
    v.op = op; v.addr = addr; v.data = data;
    v.resp = resp; v.nresp = nresp;
    v.exp_data = exp_data; v.exp_err = exp_err;
    v.toggle = toggle; v.hold = hold;
    if (op == 8'h01) begin
      v.nwords = 5;
      v.words[0] = 32'h01000004;
      v.words[1] = addr[31:0];  v.words[2] = addr[63:32];
      v.words[3] = data[31:0];  v.words[4] = data[63:32];
    end else if (op == 8'h02) begin
      v.nwords = 3;
      v.words[0] = 32'h02000002;
      v.words[1] = addr[31:0];  v.words[2] = addr[63:32];
    end else begin
      v.nwords = 0;
    end
    return v;
  endfunction

  // driver: one full command, from handshake to consumed response
  task automatic run_txn(input vec_t v, input string tag);
    int cyc;
    int i;
    logic        prev_stall;
    logic [31:0] prev_bits;
    exp_q.delete();
    for (int k = 0; k < v.nwords; k++) exp_q.push_back(v.words[k]);
    cmd_valid  = 1'b1;
    cmd_opcode = v.op;
    cmd_addr   = v.addr;
    cmd_data   = v.data;
    cyc = 0;
    while (!cmd_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_data  = '0;
    if (v.nwords == 0) begin
      chk({tag, "_no_req"}, fsim_req_valid, 0);
    end else begin
      chk({tag, "_req_latency"}, fsim_req_valid, 1);
    end

    prev_stall = 1'b0;
    prev_bits  = '0;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 100) begin
      fsim_req_ready = v.toggle ? (cyc % 2 == 1) : 1'b1;
      if (prev_stall) chk({tag, "_req_hold"}, {fsim_req_valid, fsim_req_bits}, {1'b1, prev_bits});
      if (fsim_req_valid && fsim_req_ready) chk({tag, "_req_word"}, fsim_req_bits, exp_q.pop_front());
      prev_stall = fsim_req_valid && !fsim_req_ready;
      prev_bits  = fsim_req_bits;
      @(negedge clk);
      cyc++;
    end
    fsim_req_ready = 1'b0;
    if (cyc >= 100) chk({tag, "_req_timeout"}, exp_q.size(), 0);
    if (!v.toggle) chk({tag, "_req_cycles"}, cyc, v.nwords);
    chk({tag, "_req_done"}, fsim_req_valid, 0);

    i = 0;
    cyc = 0;
    while (i < v.nresp && cyc < 100) begin
      fsim_resp_valid = 1'b1;
      fsim_resp_bits  = v.resp[i];
      if (fsim_resp_ready) i++;
      @(negedge clk);
      cyc++;
    end
    fsim_resp_valid = 1'b0;
    fsim_resp_bits  = '0;
    if (cyc >= 100) chk({tag, "_resp_timeout"}, i, v.nresp);

    chk({tag, "_rsp_valid"}, rsp_valid, 1);
    chk({tag, "_rsp_data"}, rsp_data, v.exp_data);
    chk({tag, "_rsp_err"}, rsp_err, v.exp_err);
    for (int h = 0; h < v.hold; h++) begin
      rsp_ready = 1'b0;
      @(negedge clk);
      chk({tag, "_rsp_hold"}, {rsp_valid, rsp_err, rsp_data}, {1'b1, v.exp_err, v.exp_data});
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, "_rsp_cleared"}, rsp_valid, 0);
    chk({tag, "_back_idle"}, cmd_ready, 1);
  endtask

  initial begin
    vecs[0] = mk(8'h01, 64'h1_0000_0040, 64'hDEADBEEF_CAFEF00D, {32'h0, 32'h0}, 1,
                 64'h0, 1'b0, 1'b0, 0);
    vecs[1] = mk(8'h02, 64'h80, 64'h123, {32'h33334444, 32'h11112222}, 2,
                 64'h33334444_11112222, 1'b0, 1'b0, 0);
    vecs[2] = mk(8'h01, 64'h1_0000_0040, 64'hDEADBEEF_CAFEF00D, {32'h0, 32'h5}, 1,
                 64'h0, 1'b1, 1'b1, 5);
    vecs[3] = mk(8'h7F, 64'h44, 64'h55, {32'h0, 32'h0}, 0,
                 64'h0, 1'b1, 1'b0, 0);
    vecs[4] = mk(8'h02, 64'hA5A50000_12345678, 64'h0, {32'h00000001, 32'hFFFFFFFF}, 2,
                 64'h00000001_FFFFFFFF, 1'b0, 1'b1, 2);
    vecs[5] = mk(8'h01, 64'h0000_0010_0000_0008, 64'h0123_4567_89AB_CDEF, {32'h0, 32'h80000000}, 1,
                 64'h0, 1'b1, 1'b0, 1);

    reset           = 1'b1;
    cmd_valid       = 1'b0;
    cmd_opcode      = '0;
    cmd_addr        = '0;
    cmd_data        = '0;
    fsim_req_ready  = 1'b0;
    fsim_resp_valid = 1'b0;
    fsim_resp_bits  = '0;
    rsp_ready       = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_cmd_ready", cmd_ready, 1);

    for (int n = 0; n < 6; n++) begin
      run_txn(vecs[n], $sformatf("vec%0d", n));
    end

    // reset while a WRITE is in its data phase
    cmd_valid      = 1'b1;
    cmd_opcode     = 8'h01;
    cmd_addr       = 64'h2_0000_0100;
    cmd_data       = 64'h1111_2222_3333_4444;
    fsim_req_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 0; k < 3; k++) @(negedge clk);
    chk("pre_reset_state_data", dbg_state, 3'd3);
    reset = 1'b1;
    #1;
    chk_all_zero("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("after_reset_no_word", fsim_req_valid, 0);
    end
    fsim_req_ready = 1'b0;
    run_txn(vecs[1], "post_reset_read");

`ifdef FSIM_TIMEOUT_EN
    // READ with no response: time out 16 cycles into WAIT_RSP
    cmd_valid      = 1'b1;
    cmd_opcode     = 8'h02;
    cmd_addr       = 64'h300;
    fsim_req_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 0; k < 3; k++) @(negedge clk);
    fsim_req_ready = 1'b0;
    chk("tmo_req_done", fsim_req_valid, 0);
    for (int k = 0; k < 16; k++) begin
      chk("tmo_waiting", rsp_valid, 0);
      @(negedge clk);
    end
    chk("tmo_rsp_valid", rsp_valid, 1);
    chk("tmo_rsp_err", rsp_err, 1);
    chk("tmo_rsp_data", rsp_data, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready       = 1'b0;
    fsim_resp_valid = 1'b1;
    fsim_resp_bits  = 32'hBAD0BAD0;
    chk("tmo_drain_ready", fsim_resp_ready, 1);
    @(negedge clk);
    fsim_resp_valid = 1'b0;
    chk("tmo_drain_no_rsp", rsp_valid, 0);
    chk("tmo_drain_idle", cmd_ready, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
